// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm controller: state encoding and time-of-day limits.
package alarm_pkg;

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } alarm_state_t;

  localparam int SEC_PER_MIN = 60;
  localparam int HOUR_MAX    = 23;
  localparam int MIN_MAX     = 59;

  localparam int RING_CNT_W  = 6;
  localparam int SNZ_CNT_W   = 10;

endpackage

// File: rtl/alarm_ctrl_tick_counter.sv
// Loadable down-counter advanced by the one-second tick; stops at zero.
module tick_counter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         zero,
  output logic         last
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);
  // last marks the value that the next tick will take to zero
  assign last = (cnt == W'(1));

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: trigger on time match, ring with timeout, bounded snooze, stop.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sec_tick,
  input  logic [5:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  input  logic [5:0] limit_hour,
  input  logic [5:0] limit_min,
  input  logic       alarm_en,
  input  logic       stop_pulse,
  input  logic       snooze_pulse,
  output logic [1:0] state,
  output logic       ring,
  output logic       beep,
  output logic       missed,
  output logic [1:0] snooze_used
);

  localparam logic [RING_CNT_W-1:0] RING_LIMIT = RING_CNT_W'(RING_SECS);
  localparam logic [SNZ_CNT_W-1:0]  SNZ_LOAD   = SNZ_CNT_W'(SNOOZE_MIN * SEC_PER_MIN);
  localparam logic [1:0]            SNZ_MAX    = 2'(MAX_SNOOZE);

  alarm_state_t          st;
  logic [RING_CNT_W-1:0] ring_cnt;
  logic [RING_CNT_W-1:0] ring_nxt;
  logic                  match;
  logic                  snz_take;
  logic                  snz_tick;
  logic                  snz_zero;
  logic                  snz_last;
  logic                  snz_expire;

  assign ring_nxt = ring_cnt + 6'd1;

  // cur_sec==0 keeps a stopped alarm from re-firing later in the same minute
  assign match = sec_tick && (cur_hour == limit_hour) && (cur_min == limit_min)
                 && (cur_sec == 6'd0);

  assign snz_take = alarm_en && !stop_pulse && snooze_pulse && (st == RINGING)
                    && (snooze_used < SNZ_MAX);
  assign snz_tick = alarm_en && !stop_pulse && sec_tick && (st == SNOOZE) && !snz_zero;
  assign snz_expire = snz_tick && snz_last;

  tick_counter #(
    .W (SNZ_CNT_W)
  ) u_snooze_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (!alarm_en),
    .load     (snz_take),
    .load_val (SNZ_LOAD),
    .tick     (snz_tick),
    .zero     (snz_zero),
    .last     (snz_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= OFF;
      ring        <= 1'b0;
      beep        <= 1'b0;
      missed      <= 1'b0;
      snooze_used <= 2'd0;
      ring_cnt    <= '0;
    end else if (!alarm_en) begin
      st          <= OFF;
      ring        <= 1'b0;
      beep        <= 1'b0;
      missed      <= 1'b0;
      snooze_used <= 2'd0;
      ring_cnt    <= '0;
    end else begin
      if (stop_pulse) missed <= 1'b0;
      case (st)
        OFF: st <= ARMED;
        ARMED: begin
          if (!stop_pulse && match) begin
            st          <= RINGING;
            ring        <= 1'b1;
            beep        <= 1'b0;
            missed      <= 1'b0;
            snooze_used <= 2'd0;
            ring_cnt    <= '0;
          end
        end
        RINGING: begin
          if (stop_pulse) begin
            st          <= ARMED;
            ring        <= 1'b0;
            beep        <= 1'b0;
            snooze_used <= 2'd0;
          end else if (snz_take) begin
            st          <= SNOOZE;
            ring        <= 1'b0;
            beep        <= 1'b0;
            snooze_used <= snooze_used + 2'd1;
          end else if (sec_tick) begin
            if (ring_nxt == RING_LIMIT) begin
              st     <= ARMED;
              ring   <= 1'b0;
              beep   <= 1'b0;
              missed <= 1'b1;
            end else begin
              ring_cnt <= ring_nxt;
              beep     <= ~beep;
            end
          end
        end
        SNOOZE: begin
          if (stop_pulse) begin
            st          <= ARMED;
            snooze_used <= 2'd0;
          end else if (snz_expire) begin
            st       <= RINGING;
            ring     <= 1'b1;
            beep     <= 1'b0;
            ring_cnt <= '0;
          end
        end
      endcase
    end
  end

  assign state = st;

endmodule
